// File: rtl/uart_imem_loader_pkg.sv
// Shared encodings and constants for the UART instruction-memory loader.
// Imported by the loader top and its input synchronizer.
package uart_imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } load_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_MARKER  = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_MAX     = 2'b11
    } end_cause_t;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;

    localparam logic [31:0] END_MARKER_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_imem_loader_sync.sv
// Multi-stage synchronizer for an asynchronous strobe plus a one-clock
// rising-edge pulse taken from the last two synchronized stages.
module uart_word_sync
    import uart_imem_loader_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_p,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst_p == RST_ENABLE) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign rise = sync_reg[STAGES-2] & ~sync_reg[STAGES-1];

endmodule

// File: rtl/uart_imem_loader.sv
// Writes UART-received words into instruction memory and holds the CPU in
// reset until the download ends (end marker, idle timeout or full image).
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]       END_MARKER  = END_MARKER_DEFAULT,
    parameter int                MAX_WORDS   = 4096,
    parameter int                CNT_W       = 13,
    parameter int                TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_hold,
    output logic              load_done,
    output logic [1:0]        end_cause,
    output logic [CNT_W-1:0]  word_count,
    output logic [31:0]       checksum
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic              word_rise;
    load_state_t       state_reg;
    logic              pending_reg;
    logic [31:0]       word_latch_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              cpu_rst_hold_reg;
    logic              load_done_reg;
    end_cause_t        end_cause_reg;
    logic [CNT_W-1:0]  word_count_reg;
    logic [31:0]       checksum_reg;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] addr_next;

    uart_word_sync #(.STAGES(2)) u_sync (
        .clk      (clk),
        .rst_p    (rst_p),
        .async_in (word_valid),
        .rise     (word_rise)
    );

    assign count_next = word_count_reg + CNT_W'(1);
    assign addr_next  = BASE_ADDR + (ADDR_W'(word_count_reg) << 2);

    always_ff @(posedge clk) begin
        if (rst_p == RST_ENABLE) begin
            state_reg        <= ST_WAIT;
            pending_reg      <= FALSE;
            word_latch_reg   <= '0;
            timer_reg        <= '0;
            imem_we_reg      <= FALSE;
            imem_addr_reg    <= BASE_ADDR;
            imem_wdata_reg   <= '0;
            cpu_rst_hold_reg <= TRUE;
            load_done_reg    <= FALSE;
            end_cause_reg    <= CAUSE_NONE;
            word_count_reg   <= '0;
            checksum_reg     <= '0;
        end else begin
            imem_we_reg <= FALSE;
            // The idle timer saturates so it cannot wrap while waiting for the first word.
            if (state_reg != ST_DONE && timer_reg != TMR_LAST) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
            case (state_reg)
                ST_WAIT: begin
                    if (pending_reg) begin
                        pending_reg <= FALSE;
                        if (word_latch_reg == END_MARKER) begin
                            state_reg        <= ST_DONE;
                            end_cause_reg    <= CAUSE_MARKER;
                            cpu_rst_hold_reg <= FALSE;
                            load_done_reg    <= TRUE;
                        end else begin
                            state_reg      <= ST_WRITE;
                            imem_we_reg    <= TRUE;
                            imem_addr_reg  <= addr_next;
                            imem_wdata_reg <= word_latch_reg;
                        end
                    end else if (word_count_reg != '0 && timer_reg == TMR_LAST) begin
                        state_reg        <= ST_DONE;
                        end_cause_reg    <= CAUSE_TIMEOUT;
                        cpu_rst_hold_reg <= FALSE;
                        load_done_reg    <= TRUE;
                    end
                end
                ST_WRITE: begin
                    word_count_reg <= count_next;
                    checksum_reg   <= checksum_reg ^ imem_wdata_reg;
                    if (count_next == CNT_W'(MAX_WORDS)) begin
                        state_reg        <= ST_DONE;
                        end_cause_reg    <= CAUSE_MAX;
                        cpu_rst_hold_reg <= FALSE;
                        load_done_reg    <= TRUE;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                default: begin
                end
            endcase
            // A new word overrides the pending clear above, so a rise during WRITE is kept.
            if (state_reg != ST_DONE && word_rise) begin
                pending_reg    <= TRUE;
                word_latch_reg <= word_data;
                timer_reg      <= '0;
            end
        end
    end

    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign cpu_rst_hold = cpu_rst_hold_reg;
    assign load_done    = load_done_reg;
    assign end_cause    = end_cause_reg;
    assign word_count   = word_count_reg;
    assign checksum     = checksum_reg;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: vector table for download sequences,
// hand-written sequences for timeout, reset, back-to-back and idle cases.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst_p = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_hold;
    logic        load_done;
    logic [1:0]  end_cause;
    logic [12:0] word_count;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;
    logic [47:0] wq[$];
    bit hold_dropped = 1'b0;

    uart_imem_loader #(
        .ADDR_W(16), .BASE_ADDR(16'h0000), .END_MARKER(32'hFFFF_FFFF),
        .MAX_WORDS(4), .CNT_W(13), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst_p(rst_p), .word_valid(word_valid), .word_data(word_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_hold(cpu_rst_hold), .load_done(load_done), .end_cause(end_cause),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
        if (!cpu_rst_hold) hold_dropped = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst_first;
        logic [31:0] word;
        bit          exp_we;
        logic [15:0] exp_addr;
        logic [1:0]  exp_cause;
        logic [12:0] exp_count;
        logic [31:0] exp_chk;
        bit          exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_p = 1'b1;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_p = 1'b0;
        wq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
        chk({tag, "_wdata"}, imem_wdata, 32'h0);
        chk({tag, "_hold"}, 32'(cpu_rst_hold), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_cause"}, 32'(end_cause), 32'd0);
        chk({tag, "_count"}, 32'(word_count), 32'd0);
        chk({tag, "_chk"}, checksum, 32'h0);
    endtask

    // k counts posedges after word_valid rises; lat = first k with imem_we seen.
    task automatic send_word(input logic [31:0] d, input int nclk, output int lat, output int lat_done);
        @(negedge clk);
        word_data = d;
        word_valid = 1'b1;
        lat = -1;
        lat_done = -1;
        for (int k = 1; k <= nclk; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) word_valid = 1'b0;
            if (imem_we && lat < 0) lat = k;
            if (load_done && lat_done < 0) lat_done = k;
        end
        #1;
    endtask

    task automatic check_one_write(input string tag, input logic [15:0] a, input logic [31:0] d);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'd1);
        if (wq.size() > 0) begin
            chk({tag, "_waddr"}, 32'(wq[0][47:32]), 32'(a));
            chk({tag, "_wdata"}, wq[0][31:0], d);
        end
        wq.delete();
    endtask

    initial begin
        int lat;
        int lat_done;
        vecs[0] = '{1'b1, 32'h0000_0013, 1'b1, 16'h0000, 2'b00, 13'd1, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b0, 32'h0010_0093, 1'b1, 16'h0004, 2'b00, 13'd2, 32'h0010_0080, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0000, 2'b01, 13'd2, 32'h0010_0080, 1'b1};
        vecs[3] = '{1'b1, 32'h1111_1111, 1'b1, 16'h0000, 2'b00, 13'd1, 32'h1111_1111, 1'b0};
        vecs[4] = '{1'b0, 32'h2222_2222, 1'b1, 16'h0004, 2'b00, 13'd2, 32'h3333_3333, 1'b0};
        vecs[5] = '{1'b0, 32'h3333_3333, 1'b1, 16'h0008, 2'b00, 13'd3, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h4444_4444, 1'b1, 16'h000C, 2'b11, 13'd4, 32'h4444_4444, 1'b1};
        vecs[7] = '{1'b0, 32'h5555_5555, 1'b0, 16'h0000, 2'b11, 13'd4, 32'h4444_4444, 1'b1};

        do_reset();
        check_reset_state("init");

        // End marker sequence and max-words sequence
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_first) do_reset();
            send_word(vecs[i].word, 8, lat, lat_done);
            if (vecs[i].exp_we) begin
                check_one_write($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].word);
                chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
            end else begin
                chk($sformatf("v%0d_nwr", i), 32'(wq.size()), 32'd0);
                wq.delete();
            end
            chk($sformatf("v%0d_count", i), 32'(word_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_chk", i), checksum, vecs[i].exp_chk);
            chk($sformatf("v%0d_cause", i), 32'(end_cause), 32'(vecs[i].exp_cause));
            chk($sformatf("v%0d_done", i), 32'(load_done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_hold", i), 32'(cpu_rst_hold), 32'(!vecs[i].exp_done));
            $display("vec %0d word=0x%08h count=%0d cause=%0d done=%0d", i, vecs[i].word, word_count, end_cause, load_done);
        end

        // Idle timeout: load_done 100 clocks after the edge that detects the rise (k=2)
        do_reset();
        send_word(32'hDEAD_BEEF, 130, lat, lat_done);
        check_one_write("tmo", 16'h0000, 32'hDEAD_BEEF);
        chk("tmo_done_lat", 32'(lat_done), 32'd102);
        chk("tmo_cause", 32'(end_cause), 32'd2);
        chk("tmo_hold", 32'(cpu_rst_hold), 32'd0);
        $display("timeout: done at k=%0d cause=%0d", lat_done, end_cause);

        // Reset mid-download restarts at the base address
        do_reset();
        hold_dropped = 1'b0;
        send_word(32'h0000_0011, 8, lat, lat_done);
        send_word(32'h0000_0022, 8, lat, lat_done);
        chk("rst_pre_count", 32'(word_count), 32'd2);
        do_reset();
        check_reset_state("midrst");
        send_word(32'hAAAA_AAAA, 8, lat, lat_done);
        check_one_write("midrst_w", 16'h0000, 32'hAAAA_AAAA);
        chk("midrst_count", 32'(word_count), 32'd1);
        chk("midrst_chk", checksum, 32'hAAAA_AAAA);
        chk("midrst_hold_kept", 32'(hold_dropped), 32'd0);
        $display("midreset: count=%0d checksum=0x%08h", word_count, checksum);

        // Second rise lands while the first word is in WRITE
        do_reset();
        @(negedge clk); word_data = 32'h0BAD_F00D; word_valid = 1'b1;
        @(posedge clk); @(negedge clk); word_valid = 1'b0;
        @(posedge clk); @(negedge clk); word_data = 32'h1234_5678; word_valid = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        word_valid = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        #1;
        chk("b2b_nwr", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("b2b_a0", 32'(wq[0][47:32]), 32'h0);
            chk("b2b_d0", wq[0][31:0], 32'h0BAD_F00D);
            chk("b2b_a1", 32'(wq[1][47:32]), 32'h4);
            chk("b2b_d1", wq[1][31:0], 32'h1234_5678);
        end
        chk("b2b_count", 32'(word_count), 32'd2);
        $display("back-to-back: writes=%0d count=%0d", wq.size(), word_count);

        // No words at all: no timeout, CPU stays held
        do_reset();
        repeat (1000) @(posedge clk);
        @(negedge clk);
        #1;
        chk("idle_nwr", 32'(wq.size()), 32'd0);
        chk("idle_done", 32'(load_done), 32'd0);
        chk("idle_hold", 32'(cpu_rst_hold), 32'd1);
        chk("idle_cause", 32'(end_cause), 32'd0);
        $display("idle: done=%0d hold=%0d", load_done, cpu_rst_hold);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
